// File: rtl/bitty_run_sequencer.sv
// Instruction sequencer for the bitty core: fetch, issue, wait for done,
// then load the branch-logic next PC. Supports run, step, halt and a watchdog.
module bitty_run_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] core_instr,
    output logic               core_run,
    input  logic               core_done,
    input  logic [ADDR_W-1:0]  branch_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               err,
    output logic [15:0]        instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_UPDATE,
        S_ERROR
    } state_t;

    localparam logic [1:0] FETCH_LAST = 2'(MEM_LAT - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [15:0]          count_q, count_d;
    logic                 err_q, err_d;
    // mode_q high means single-step: return to IDLE after one retirement
    logic                 mode_q, mode_d;
    logic [1:0]           wait_q, wait_d;
    logic [7:0]           tmo_q, tmo_d;

    // Next-state and datapath updates for the fetch/issue/exec/update loop
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        err_d   = err_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (step) begin
                    state_d = S_FETCH;
                    mode_d  = 1'b1;
                    wait_d  = 2'd0;
                end else if (start && !halt_req) begin
                    state_d = S_FETCH;
                    mode_d  = 1'b0;
                    wait_d  = 2'd0;
                end
            end
            S_FETCH: begin
                if (wait_q == FETCH_LAST) begin
                    instr_d = mem_rdata;
                    wait_d  = 2'd0;
                    state_d = S_ISSUE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_ISSUE: begin
                tmo_d   = 8'd0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (core_done) begin
                    state_d = S_UPDATE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = tmo_q + 8'd1;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_UPDATE: begin
                pc_d    = branch_pc;
                count_d = count_q + 16'd1;
                if (mode_q || halt_req || !start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = 2'd0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
            wait_q  <= 2'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    assign instr_count = count_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign core_instr  = instr_q;
    assign err         = err_q;
    assign core_run    = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_bitty_run_sequencer.sv
// Randomized self-checking bench for bitty_run_sequencer.
// Instance u_a: MEM_LAT=1, TIMEOUT=4. Instance u_b: MEM_LAT=2, TIMEOUT=4.
module tb_bitty_run_sequencer;

    localparam int TMO  = 4;
    localparam int A_ML = 1;

    logic clk = 1'b0;
    // Free-running clock, period 10
    always #5 clk = ~clk;

    logic        a_reset, start, step, halt_req, core_done;
    logic [7:0]  mem_addr, branch_pc, pc;
    logic [15:0] mem_rdata, core_instr, instr_count;
    logic        core_run, busy, err;
    logic [15:0] mem [256];
    logic [7:0]  br_tab [256];

    assign mem_rdata = mem[mem_addr];
    assign branch_pc = br_tab[pc];

    bitty_run_sequencer #(
        .ADDR_W(8), .INSTR_W(16), .MEM_LAT(A_ML), .TIMEOUT(TMO)
    ) u_a (
        .clk(clk), .reset(a_reset), .start(start), .step(step),
        .halt_req(halt_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .core_instr(core_instr), .core_run(core_run),
        .core_done(core_done), .branch_pc(branch_pc), .pc(pc),
        .busy(busy), .err(err), .instr_count(instr_count)
    );

    logic        b_reset, b_start, b_step, b_halt, b_done;
    logic [7:0]  b_mem_addr, b_branch_pc, b_pc;
    logic [15:0] b_rdata, b_instr, b_count;
    logic        b_run, b_busy, b_err;

    assign b_branch_pc = 8'h33;

    bitty_run_sequencer #(
        .ADDR_W(8), .INSTR_W(16), .MEM_LAT(2), .TIMEOUT(TMO)
    ) u_b (
        .clk(clk), .reset(b_reset), .start(b_start), .step(b_step),
        .halt_req(b_halt), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
        .core_instr(b_instr), .core_run(b_run),
        .core_done(b_done), .branch_pc(b_branch_pc), .pc(b_pc),
        .busy(b_busy), .err(b_err), .instr_count(b_count)
    );

    int errs = 0;
    int checks = 0;

    int          cyc_n = 0;
    int          done_at = -1;
    int          stop_after = 0;
    int          dly_q[$];
    int          run_cyc[$];
    logic [7:0]  run_pc[$];
    logic [15:0] run_ins[$];

    logic [7:0]  m_pc;
    logic [15:0] m_cnt;
    int          exp_cyc[$];
    logic [7:0]  exp_pc[$];

    // One clock of u_a: log issue pulses and play the core's done pulse
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        core_done = 1'b0;
        if (core_run) begin
            run_cyc.push_back(cyc_n);
            run_pc.push_back(pc);
            run_ins.push_back(core_instr);
            if (dly_q.size() > 0) done_at = cyc_n + dly_q.pop_front();
            else done_at = cyc_n + 1000000;
            if (run_cyc.size() == stop_after) start = 1'b0;
        end
        if (cyc_n == done_at) core_done = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        run_cyc.delete();
        run_pc.delete();
        run_ins.delete();
        dly_q.delete();
        done_at = -1;
        stop_after = 0;
    endtask

    task automatic a_reset_seq();
        a_reset = 1'b1;
        start = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        core_done = 1'b0;
        cyc();
        a_reset = 1'b0;
        clear_log();
        m_pc = 8'd0;
        m_cnt = 16'd0;
    endtask

    // Continuous run of n instructions; stimulus only
    task automatic drive_run(input int n, output bit ok);
        ok = 1'b0;
        stop_after = n;
        start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            cyc();
            if (run_cyc.size() >= n && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Reference: issue time of each instruction and the PC it runs at
    function automatic void model_run(input int s, input int n,
                                      input int d[$]);
        int t;
        t = s + 1 + A_ML;
        exp_cyc.delete();
        exp_pc.delete();
        for (int i = 0; i < n; i++) begin
            exp_cyc.push_back(t);
            exp_pc.push_back(m_pc);
            t = t + d[i] + A_ML + 2;
            m_pc = br_tab[m_pc];
            m_cnt = m_cnt + 16'd1;
        end
    endfunction

    task automatic test_reset();
        a_reset = 1'b1;
        b_reset = 1'b1;
        start = 0; step = 0; halt_req = 0; core_done = 0;
        b_start = 0; b_step = 0; b_halt = 0; b_done = 0;
        b_rdata = 16'h0;
        tick();
        tick();
        checks++;
        if ({pc, core_instr, instr_count, mem_addr} !== 48'h0) begin
            errs++;
            $display("FAIL reset_regs: got pc=%h ins=%h cnt=%h addr=%h want 0",
                     pc, core_instr, instr_count, mem_addr);
        end
        checks++;
        if ({core_run, busy, err, b_busy, b_err} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags: got run=%b busy=%b err=%b want 0",
                     core_run, busy, err);
        end
        a_reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if (busy !== 1'b0 || core_run !== 1'b0) begin
            errs++;
            $display("FAIL idle_hold: got busy=%b run=%b want 0", busy, core_run);
        end
        clear_log();
        m_pc = 8'd0;
        m_cnt = 16'd0;
    endtask

    task automatic test_continuous();
        int s;
        int d[$];
        bit ok;
        a_reset_seq();
        for (int i = 0; i < 256; i++) br_tab[i] = 8'(i + 1);
        d = '{3, 3, 3, 3};
        dly_q = d;
        s = cyc_n;
        drive_run(4, ok);
        model_run(s, 4, d);
        checks++;
        if (!ok || run_cyc.size() != 4) begin
            errs++;
            $display("FAIL cont_runs: got %0d runs (done=%0b) want 4",
                     run_cyc.size(), ok);
        end
        for (int i = 0; i < 4 && i < run_cyc.size(); i++) begin
            checks++;
            if (run_pc[i] !== exp_pc[i] || run_cyc[i] != exp_cyc[i]) begin
                errs++;
                $display("FAIL cont_issue%0d: got pc=%h cyc=%0d want pc=%h cyc=%0d",
                         i, run_pc[i], run_cyc[i], exp_pc[i], exp_cyc[i]);
            end
            checks++;
            if (run_ins[i] !== mem[exp_pc[i]]) begin
                errs++;
                $display("FAIL cont_instr%0d: got %h want %h",
                         i, run_ins[i], mem[exp_pc[i]]);
            end
        end
        checks++;
        if (pc !== m_pc || instr_count !== m_cnt || busy !== 1'b0) begin
            errs++;
            $display("FAIL cont_end: got pc=%h cnt=%0d busy=%b want pc=%h cnt=%0d busy=0",
                     pc, instr_count, busy, m_pc, m_cnt);
        end
    endtask

    task automatic test_random_run();
        int s;
        int n;
        int d[$];
        bit ok;
        for (int it = 0; it < 3; it++) begin
            clear_log();
            for (int i = 0; i < 256; i++) br_tab[i] = 8'($urandom);
            n = $urandom_range(5, 10);
            d.delete();
            for (int i = 0; i < n; i++) d.push_back($urandom_range(1, TMO));
            dly_q = d;
            s = cyc_n;
            drive_run(n, ok);
            model_run(s, n, d);
            checks++;
            if (!ok || run_cyc.size() != n) begin
                errs++;
                $display("FAIL rand%0d_runs: got %0d want %0d", it,
                         run_cyc.size(), n);
            end
            for (int i = 0; i < n && i < run_cyc.size(); i++) begin
                checks++;
                if (run_pc[i] !== exp_pc[i] || run_cyc[i] != exp_cyc[i] ||
                    run_ins[i] !== mem[exp_pc[i]]) begin
                    errs++;
                    $display("FAIL rand%0d_issue%0d: got pc=%h cyc=%0d ins=%h want pc=%h cyc=%0d ins=%h",
                             it, i, run_pc[i], run_cyc[i], run_ins[i],
                             exp_pc[i], exp_cyc[i], mem[exp_pc[i]]);
                end
            end
            checks++;
            if (pc !== m_pc || instr_count !== m_cnt || err !== 1'b0) begin
                errs++;
                $display("FAIL rand%0d_end: got pc=%h cnt=%0d err=%b want pc=%h cnt=%0d err=0",
                         it, pc, instr_count, err, m_pc, m_cnt);
            end
        end
    endtask

    task automatic test_step();
        logic [7:0]  p0;
        logic [15:0] c0;
        clear_log();
        p0 = m_pc;
        c0 = m_cnt;
        dly_q = '{3};
        step = 1'b1;
        cyc();
        step = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (run_cyc.size() == 1 && cyc_n == run_cyc[0] + 1) begin
                step = 1'b1;
                cyc();
                step = 1'b0;
            end
        end
        m_pc = br_tab[p0];
        m_cnt = c0 + 16'd1;
        checks++;
        if (run_cyc.size() != 1) begin
            errs++;
            $display("FAIL step_runs: got %0d want 1", run_cyc.size());
        end
        checks++;
        if (pc !== m_pc || instr_count !== m_cnt || busy !== 1'b0) begin
            errs++;
            $display("FAIL step_end: got pc=%h cnt=%0d busy=%b want pc=%h cnt=%0d busy=0",
                     pc, instr_count, busy, m_pc, m_cnt);
        end
        clear_log();
        dly_q = '{2};
        start = 1'b1;
        step = 1'b1;
        cyc();
        step = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (run_cyc.size() > 0 && cyc_n == run_cyc[0] + 4) start = 1'b0;
        end
        start = 1'b0;
        m_pc = br_tab[m_pc];
        m_cnt = m_cnt + 16'd1;
        checks++;
        if (run_cyc.size() != 1 || instr_count !== m_cnt || pc !== m_pc) begin
            errs++;
            $display("FAIL step_wins: got runs=%0d cnt=%0d pc=%h want runs=1 cnt=%0d pc=%h",
                     run_cyc.size(), instr_count, pc, m_cnt, m_pc);
        end
    endtask

    task automatic test_halt();
        a_reset_seq();
        for (int i = 0; i < 256; i++) br_tab[i] = 8'(i + 1);
        for (int i = 0; i < 20; i++) dly_q.push_back(2);
        stop_after = 100;
        start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            cyc();
            if (run_cyc.size() > 0 && run_pc[$] == 8'd5 &&
                cyc_n == run_cyc[$] + 1) halt_req = 1'b1;
        end
        checks++;
        if (run_cyc.size() != 6) begin
            errs++;
            $display("FAIL halt_runs: got %0d want 6", run_cyc.size());
        end
        checks++;
        if (pc !== 8'd6 || instr_count !== 16'd6 || busy !== 1'b0) begin
            errs++;
            $display("FAIL halt_end: got pc=%h cnt=%0d busy=%b want pc=06 cnt=6 busy=0",
                     pc, instr_count, busy);
        end
        start = 1'b0;
        halt_req = 1'b0;
        m_pc = 8'd6;
        m_cnt = 16'd6;
    endtask

    task automatic test_timeout();
        int  c;
        bit  got;
        clear_log();
        got = 1'b0;
        stop_after = 1;
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (run_cyc.size() == 1) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errs++;
            $display("FAIL tmo_issue: got no core_run want one");
            return;
        end
        c = run_cyc[0];
        while (cyc_n < c + TMO) cyc();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL tmo_early: got err=%b busy=%b want err=0 busy=1",
                     err, busy);
        end
        cyc();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || pc !== m_pc ||
            instr_count !== m_cnt) begin
            errs++;
            $display("FAIL tmo_err: got err=%b busy=%b pc=%h cnt=%0d want 1 0 %h %0d",
                     err, busy, pc, instr_count, m_pc, m_cnt);
        end
        start = 1'b1;
        step = 1'b1;
        repeat (10) cyc();
        start = 1'b0;
        step = 1'b0;
        checks++;
        if (run_cyc.size() != 1 || pc !== m_pc || err !== 1'b1) begin
            errs++;
            $display("FAIL tmo_sticky: got runs=%0d pc=%h err=%b want 1 %h 1",
                     run_cyc.size(), pc, err, m_pc);
        end
        #2;
        a_reset = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0 || pc !== 8'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL tmo_reset: got err=%b pc=%h busy=%b want 0 00 0",
                     err, pc, busy);
        end
        cyc();
        a_reset = 1'b0;
        clear_log();
        m_pc = 8'd0;
        m_cnt = 16'd0;
    endtask

    task automatic test_timeout_edge();
        int s;
        int d[$];
        bit ok;
        clear_log();
        d = '{TMO};
        dly_q = d;
        s = cyc_n;
        drive_run(1, ok);
        model_run(s, 1, d);
        checks++;
        if (!ok || err !== 1'b0 || pc !== m_pc || instr_count !== m_cnt) begin
            errs++;
            $display("FAIL tmo_edge: got err=%b pc=%h cnt=%0d want 0 %h %0d",
                     err, pc, instr_count, m_pc, m_cnt);
        end
    endtask

    task automatic test_wrap();
        int s;
        int d[$];
        bit ok;
        a_reset_seq();
        br_tab[0] = 8'hFF;
        br_tab[255] = 8'h00;
        force u_a.count_q = 16'hFFFF;
        cyc();
        release u_a.count_q;
        m_cnt = 16'hFFFF;
        d = '{2, 3};
        dly_q = d;
        s = cyc_n;
        drive_run(2, ok);
        model_run(s, 2, d);
        checks++;
        if (!ok || run_cyc.size() != 2 || run_pc[1] !== 8'hFF) begin
            errs++;
            $display("FAIL wrap_runs: got runs=%0d want 2 with second at pc=ff",
                     run_cyc.size());
        end
        checks++;
        if (pc !== m_pc || instr_count !== m_cnt) begin
            errs++;
            $display("FAIL wrap_end: got pc=%h cnt=%h want pc=%h cnt=%h",
                     pc, instr_count, m_pc, m_cnt);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [15:0] v2;
        logic [15:0] v3;
        bit got;
        b_reset = 1'b0;
        b_step = 1'b1;
        tick();
        b_step = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (b_run) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        tick();
        checks++;
        if (!got || b_pc !== 8'h33 || b_count !== 16'd1) begin
            errs++;
            $display("FAIL b_first: got pc=%h cnt=%0d want pc=33 cnt=1",
                     b_pc, b_count);
        end
        v2 = 16'($urandom) | 16'h1;
        b_rdata = v2;
        b_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (b_run) break;
        end
        tick();
        checks++;
        if (b_busy !== 1'b1 || b_instr !== v2) begin
            errs++;
            $display("FAIL b_exec: got busy=%b ins=%h want busy=1 ins=%h",
                     b_busy, b_instr, v2);
        end
        #2;
        b_reset = 1'b1;
        #1;
        checks++;
        if ({b_pc, b_instr, b_count, b_mem_addr} !== 48'h0 ||
            {b_busy, b_err, b_run} !== 3'b0) begin
            errs++;
            $display("FAIL b_async: got pc=%h ins=%h cnt=%h busy=%b want all 0",
                     b_pc, b_instr, b_count, b_busy);
        end
        b_start = 1'b0;
        tick();
        b_reset = 1'b0;
        b_start = 1'b1;
        b_rdata = 16'hDEAD;
        tick();
        v3 = 16'($urandom) ^ 16'h5A5A;
        if (v3 == 16'hDEAD) v3 = 16'h1234;
        b_rdata = v3;
        b_start = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_run !== 1'b0 || b_mem_addr !== 8'h0) begin
            errs++;
            $display("FAIL b_fetch1: got busy=%b run=%b addr=%h want 1 0 00",
                     b_busy, b_run, b_mem_addr);
        end
        tick();
        checks++;
        if (b_busy !== 1'b1 || b_run !== 1'b0 || b_mem_addr !== 8'h0) begin
            errs++;
            $display("FAIL b_fetch2: got busy=%b run=%b addr=%h want 1 0 00",
                     b_busy, b_run, b_mem_addr);
        end
        tick();
        checks++;
        if (b_run !== 1'b1 || b_instr !== v3) begin
            errs++;
            $display("FAIL b_issue: got run=%b ins=%h want run=1 ins=%h",
                     b_run, b_instr, v3);
        end
        b_reset = 1'b1;
        tick();
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    // Test sequence
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            br_tab[i] = 8'(i + 1);
        end
        test_reset();
        test_continuous();
        test_random_run();
        test_step();
        test_halt();
        test_timeout();
        test_timeout_edge();
        test_wrap();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
